sc_statemachine_entryfrogger: RTL and testbench

//  Upstream controller for the frog entry register: turns left/right/start/clear requests

---
 rtl/sc_statemachine_entryfrogger.sv | 194 +++++++++++++++++++
 tb/tb_sc_statemachine_entryfrogger.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_statemachine_entryfrogger.sv
// -----------------------------------------------------------------------------
// sc_statemachine_entryfrogger
//
// Upstream controller for the frog entry register. It turns left/right/start/
// clear requests into the 2-bit load code that selects the entry pattern:
//    00 NONE, 01 RIGHT, 10 LEFT, 11 CLEAR.
// An accepted LEFT/RIGHT move shows its code for HOLD_TICKS clocks and then
// falls back to NONE. The end of each hold is marked by a one-clock moveDone
// strobe, and accepted moves are tallied in a saturating counter.
//
// Parameters
//    HOLD_TICKS   clocks a LEFT/RIGHT code is held (1 .. 2**CNT_WIDTH-1)
//    CNT_WIDTH    width of the hold down-counter
//    MOVES_WIDTH  width of the accepted-move counter
//
// Ports
//    SC_STATEMACHINEENTRY_CLOCK_50      in   system clock, rising edge
//    SC_STATEMACHINEENTRY_RESET_InLow   in   async reset, active-low
//    SC_STATEMACHINEENTRY_left_InHigh   in   left request level (synchronised)
//    SC_STATEMACHINEENTRY_right_InHigh  in   right request level (synchronised)
//    SC_STATEMACHINEENTRY_start_InHigh  in   start request level
//    SC_STATEMACHINEENTRY_clear_InHigh  in   clear/crash level, highest priority
//    SC_STATEMACHINEENTRY_loadEntry_Out out  load code to the entry register
//    SC_STATEMACHINEENTRY_moveDone_Out  out  1-clock pulse when a hold ends
//    SC_STATEMACHINEENTRY_busy_Out      out  high while in LEFT or RIGHT
//    SC_STATEMACHINEENTRY_moves_Out     out  accepted-move count, saturating
//
// States
//    state    | meaning
//    ---------+---------------------------------------------------------
//    ST_IDLE  | waiting for a start rise, entry register held in CLEAR
//    ST_NONE  | running, no move shown, accepting a single left/right rise
//    ST_LEFT  | LEFT code shown while the hold counter runs down
//    ST_RIGHT | RIGHT code shown while the hold counter runs down
// -----------------------------------------------------------------------------
module sc_statemachine_entryfrogger #(
   parameter int unsigned HOLD_TICKS  = 4,
   parameter int unsigned CNT_WIDTH   = 24,
   parameter int unsigned MOVES_WIDTH = 8
) (
   input  logic                   SC_STATEMACHINEENTRY_CLOCK_50,
   input  logic                   SC_STATEMACHINEENTRY_RESET_InLow,
   input  logic                   SC_STATEMACHINEENTRY_left_InHigh,
   input  logic                   SC_STATEMACHINEENTRY_right_InHigh,
   input  logic                   SC_STATEMACHINEENTRY_start_InHigh,
   input  logic                   SC_STATEMACHINEENTRY_clear_InHigh,
   output logic [1:0]             SC_STATEMACHINEENTRY_loadEntry_Out,
   output logic                   SC_STATEMACHINEENTRY_moveDone_Out,
   output logic                   SC_STATEMACHINEENTRY_busy_Out,
   output logic [MOVES_WIDTH-1:0] SC_STATEMACHINEENTRY_moves_Out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_NONE  = 2'b01,
      ST_LEFT  = 2'b10,
      ST_RIGHT = 2'b11
   } state_t;

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_RIGHT = 2'b01;
   localparam logic [1:0] CODE_LEFT  = 2'b10;
   localparam logic [1:0] CODE_CLEAR = 2'b11;

   // Hold counter is loaded with HOLD_TICKS-1 so the terminal count (zero)
   // lands on the last clock the move code is shown.
   localparam logic [CNT_WIDTH-1:0]   HOLD_LOAD = CNT_WIDTH'(HOLD_TICKS - 1);
   localparam logic [MOVES_WIDTH-1:0] MOVES_MAX = {MOVES_WIDTH{1'b1}};

   logic clk;
   logic rst_n;
   assign clk   = SC_STATEMACHINEENTRY_CLOCK_50;
   assign rst_n = SC_STATEMACHINEENTRY_RESET_InLow;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [MOVES_WIDTH-1:0] moves_q, moves_d;
   logic                   done_q, done_d;
   logic                   left_prev_q, right_prev_q, start_prev_q;

   logic rise_left, rise_right, rise_start;
   logic clear;
   logic cnt_tc;

   // ---------------------------------------------------------------------------
   // Edge detection: previous-level registers update every clock, in every
   // state, so a level that is still high when NONE is re-entered is already
   // "old" and cannot retrigger a move.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_prev_q  <= 1'b0;
         right_prev_q <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         left_prev_q  <= SC_STATEMACHINEENTRY_left_InHigh;
         right_prev_q <= SC_STATEMACHINEENTRY_right_InHigh;
         start_prev_q <= SC_STATEMACHINEENTRY_start_InHigh;
      end
   end

   assign rise_left  = SC_STATEMACHINEENTRY_left_InHigh  & ~left_prev_q;
   assign rise_right = SC_STATEMACHINEENTRY_right_InHigh & ~right_prev_q;
   assign rise_start = SC_STATEMACHINEENTRY_start_InHigh & ~start_prev_q;
   assign clear      = SC_STATEMACHINEENTRY_clear_InHigh;
   assign cnt_tc     = (cnt_q == '0);

   // ---------------------------------------------------------------------------
   // State, hold counter, move counter and done strobe registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         moves_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         moves_q <= moves_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      moves_d = moves_q;
      done_d  = 1'b0;

      if (clear) begin
         // Crash/clear aborts any hold without a done strobe; the move tally
         // is kept because only reset is allowed to clear it.
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rise_start) begin
                  state_d = ST_NONE;
               end
            end

            ST_NONE: begin
               // Simultaneous left and right rises are ambiguous and dropped.
               if (rise_left ^ rise_right) begin
                  state_d = rise_left ? ST_LEFT : ST_RIGHT;
                  cnt_d   = HOLD_LOAD;
                  if (moves_q != MOVES_MAX) begin
                     moves_d = moves_q + 1'b1;
                  end
               end
            end

            ST_LEFT, ST_RIGHT: begin
               // Rises seen during a hold are deliberately not queued.
               if (cnt_tc) begin
                  state_d = ST_NONE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Moore output decode from registered state
   // ---------------------------------------------------------------------------
   always_comb begin
      SC_STATEMACHINEENTRY_loadEntry_Out = CODE_CLEAR;
      case (state_q)
         ST_IDLE:  SC_STATEMACHINEENTRY_loadEntry_Out = CODE_CLEAR;
         ST_NONE:  SC_STATEMACHINEENTRY_loadEntry_Out = CODE_NONE;
         ST_LEFT:  SC_STATEMACHINEENTRY_loadEntry_Out = CODE_LEFT;
         ST_RIGHT: SC_STATEMACHINEENTRY_loadEntry_Out = CODE_RIGHT;
         default:  SC_STATEMACHINEENTRY_loadEntry_Out = CODE_CLEAR;
      endcase
   end

   assign SC_STATEMACHINEENTRY_busy_Out     = (state_q == ST_LEFT) | (state_q == ST_RIGHT);
   assign SC_STATEMACHINEENTRY_moveDone_Out = done_q;
   assign SC_STATEMACHINEENTRY_moves_Out    = moves_q;

endmodule

// File: tb/tb_sc_statemachine_entryfrogger.sv
module tb_sc_statemachine_entryfrogger;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       left_i, right_i, start_i, clear_i;

   logic [1:0] load_a, load_b;
   logic       done_a, done_b, busy_a, busy_b;
   logic [7:0] moves_a;
   logic [1:0] moves_b;

   int checks   = 0;
   int failures = 0;

   always #10 clk = ~clk;

   sc_statemachine_entryfrogger #(.HOLD_TICKS(HOLD), .CNT_WIDTH(24), .MOVES_WIDTH(8)) dut_a (
      .SC_STATEMACHINEENTRY_CLOCK_50     (clk),
      .SC_STATEMACHINEENTRY_RESET_InLow  (rst_n),
      .SC_STATEMACHINEENTRY_left_InHigh  (left_i),
      .SC_STATEMACHINEENTRY_right_InHigh (right_i),
      .SC_STATEMACHINEENTRY_start_InHigh (start_i),
      .SC_STATEMACHINEENTRY_clear_InHigh (clear_i),
      .SC_STATEMACHINEENTRY_loadEntry_Out(load_a),
      .SC_STATEMACHINEENTRY_moveDone_Out (done_a),
      .SC_STATEMACHINEENTRY_busy_Out     (busy_a),
      .SC_STATEMACHINEENTRY_moves_Out    (moves_a)
   );

   sc_statemachine_entryfrogger #(.HOLD_TICKS(HOLD), .CNT_WIDTH(24), .MOVES_WIDTH(2)) dut_b (
      .SC_STATEMACHINEENTRY_CLOCK_50     (clk),
      .SC_STATEMACHINEENTRY_RESET_InLow  (rst_n),
      .SC_STATEMACHINEENTRY_left_InHigh  (left_i),
      .SC_STATEMACHINEENTRY_right_InHigh (right_i),
      .SC_STATEMACHINEENTRY_start_InHigh (start_i),
      .SC_STATEMACHINEENTRY_clear_InHigh (clear_i),
      .SC_STATEMACHINEENTRY_loadEntry_Out(load_b),
      .SC_STATEMACHINEENTRY_moveDone_Out (done_b),
      .SC_STATEMACHINEENTRY_busy_Out     (busy_b),
      .SC_STATEMACHINEENTRY_moves_Out    (moves_b)
   );

   // Reference model: "started" flag, remaining clocks the move code is shown,
   // pending done strobe and an unbounded move tally saturated on comparison.
   bit       m_started;
   int       m_rem;
   bit [1:0] m_code;
   bit       m_done;
   int       m_moves;
   bit       p_l, p_r, p_s;

   task automatic model_reset();
      m_started = 0; m_rem = 0; m_code = 2'b00; m_done = 0; m_moves = 0;
      p_l = 0; p_r = 0; p_s = 0;
   endtask

   task automatic model_clock(input bit l, input bit r, input bit s, input bit c);
      bit rl, rr, rs;
      rl = l & ~p_l; rr = r & ~p_r; rs = s & ~p_s;
      p_l = l; p_r = r; p_s = s;
      m_done = 0;
      if (c) begin
         m_started = 0;
         m_rem = 0;
      end else if (!m_started) begin
         if (rs) m_started = 1;
      end else if (m_rem > 0) begin
         m_rem = m_rem - 1;
         if (m_rem == 0) m_done = 1;
      end else if (rl != rr) begin
         m_rem   = HOLD;
         m_code  = rl ? 2'b10 : 2'b01;
         m_moves = m_moves + 1;
      end
   endtask

   function automatic int exp_load();
      if (!m_started) return 3;
      if (m_rem > 0)  return int'(m_code);
      return 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit l, input bit r, input bit s, input bit c);
      @(negedge clk);
      left_i = l; right_i = r; start_i = s; clear_i = c;
      @(posedge clk);
      model_clock(l, r, s, c);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " load"},    int'(load_a),  exp_load());
      chk({tag, " busy"},    int'(busy_a),  (m_started && m_rem > 0) ? 1 : 0);
      chk({tag, " done"},    int'(done_a),  int'(m_done));
      chk({tag, " moves8"},  int'(moves_a), (m_moves > 255) ? 255 : m_moves);
      chk({tag, " moves2"},  int'(moves_b), (m_moves > 3) ? 3 : m_moves);
      chk({tag, " load_b"},  int'(load_b),  exp_load());
      chk({tag, " done_b"},  int'(done_b),  int'(m_done));
      chk({tag, " busy_b"},  int'(busy_b),  (m_started && m_rem > 0) ? 1 : 0);
   endtask

   typedef struct {
      bit l, r, s, c;
      int load, busy, done, moves, moves_small;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit l, bit r, bit s, bit c,
                               int load, int busy, int done, int mv, int mvs);
      vec_t v;
      v.l = l; v.r = r; v.s = s; v.c = c;
      v.load = load; v.busy = busy; v.done = done; v.moves = mv; v.moves_small = mvs;
      return v;
   endfunction

   initial begin
      //             l r s c  load busy done moves moves_small
      vecs.push_back(mk(0,0,0,0, 3,0,0, 0,0));  // idle after reset
      vecs.push_back(mk(1,0,0,0, 3,0,0, 0,0));  // left ignored in idle
      vecs.push_back(mk(0,1,0,0, 3,0,0, 0,0));  // right ignored in idle
      vecs.push_back(mk(0,0,1,0, 0,0,0, 0,0));  // start -> NONE
      vecs.push_back(mk(1,0,0,0, 2,1,0, 1,1));  // left move, hold 1
      vecs.push_back(mk(0,0,0,0, 2,1,0, 1,1));
      vecs.push_back(mk(0,0,0,0, 2,1,0, 1,1));
      vecs.push_back(mk(0,0,0,0, 2,1,0, 1,1));  // hold 4
      vecs.push_back(mk(0,0,0,0, 0,0,1, 1,1));  // done strobe
      vecs.push_back(mk(0,0,0,0, 0,0,0, 1,1));
      vecs.push_back(mk(0,1,0,0, 1,1,0, 2,2));  // right held high
      vecs.push_back(mk(0,1,0,0, 1,1,0, 2,2));
      vecs.push_back(mk(0,1,0,0, 1,1,0, 2,2));
      vecs.push_back(mk(0,1,0,0, 1,1,0, 2,2));
      vecs.push_back(mk(0,1,0,0, 0,0,1, 2,2));
      vecs.push_back(mk(0,1,0,0, 0,0,0, 2,2));  // level still high: no retrigger
      vecs.push_back(mk(0,0,0,0, 0,0,0, 2,2));
      vecs.push_back(mk(1,1,0,0, 0,0,0, 2,2));  // both rise: ignored
      vecs.push_back(mk(0,0,0,0, 0,0,0, 2,2));
      vecs.push_back(mk(1,0,0,0, 2,1,0, 3,3));  // left move
      vecs.push_back(mk(0,1,0,0, 2,1,0, 3,3));  // right during hold dropped
      vecs.push_back(mk(0,0,0,0, 2,1,0, 3,3));
      vecs.push_back(mk(0,0,0,0, 2,1,0, 3,3));
      vecs.push_back(mk(0,0,0,0, 0,0,1, 3,3));
      vecs.push_back(mk(0,1,0,0, 1,1,0, 4,3));  // right move, small counter saturates
      vecs.push_back(mk(0,0,0,1, 3,0,0, 4,3));  // clear on 2nd hold clock
      vecs.push_back(mk(0,0,0,0, 3,0,0, 4,3));  // no done after clear
      vecs.push_back(mk(0,0,1,0, 0,0,0, 4,3));  // restart
      vecs.push_back(mk(0,0,0,0, 0,0,0, 4,3));
      vecs.push_back(mk(1,0,0,0, 2,1,0, 5,3));  // 5th move
   end

   initial begin
      left_i = 0; right_i = 0; start_i = 0; clear_i = 0;
      rst_n = 0;
      model_reset();
      #1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset load",  int'(load_a),  3);
      chk("reset busy",  int'(busy_a),  0);
      chk("reset done",  int'(done_a),  0);
      chk("reset moves", int'(moves_a), 0);
      @(negedge clk);
      rst_n = 1;

      foreach (vecs[i]) begin
         string t;
         t = $sformatf("vec%0d", i);
         step(vecs[i].l, vecs[i].r, vecs[i].s, vecs[i].c);
         chk({t, " load"},   int'(load_a),  vecs[i].load);
         chk({t, " busy"},   int'(busy_a),  vecs[i].busy);
         chk({t, " done"},   int'(done_a),  vecs[i].done);
         chk({t, " moves"},  int'(moves_a), vecs[i].moves);
         chk({t, " moves2"}, int'(moves_b), vecs[i].moves_small);
      end

      // Async reset in the middle of the LEFT hold started by the last vector.
      step(0, 0, 0, 0);
      chk("pre-reset busy", int'(busy_a), 1);
      #3;
      rst_n = 0;
      #1;
      chk("async load",  int'(load_a),  3);
      chk("async busy",  int'(busy_a),  0);
      chk("async done",  int'(done_a),  0);
      chk("async moves", int'(moves_a), 0);
      chk("async moves2", int'(moves_b), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      step(0, 0, 0, 0);
      chk("post-reset done", int'(done_a), 0);
      chk("post-reset load", int'(load_a), 3);

      // Randomized stimulus against the reference model.
      for (int n = 0; n < 3000; n++) begin
         bit l, r, s, c;
         l = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 2) == 0);
         s = ($urandom_range(0, 7) == 0);
         c = ($urandom_range(0, 79) == 0);
         step(l, r, s, c);
         chk_model($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
